// File: rtl/dds.sv
// Direct digital synthesiser: 32-bit phase accumulator driving a sine/square/triangle/sawtooth
// generator with a registered 8-bit unsigned output.
module dds #(
    parameter logic [31:0] FREQ_CTRL  = 32'd42949,
    parameter logic [11:0] PHASE_CTRL = 12'd1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] wave_select,
    output logic [7:0] wave_out
);

    localparam logic [3:0] SEL_SINE     = 4'b0001;
    localparam logic [3:0] SEL_SQUARE   = 4'b0010;
    localparam logic [3:0] SEL_TRIANGLE = 4'b0100;
    localparam logic [3:0] SEL_SAW      = 4'b1000;

    logic [31:0] acc;
    logic [11:0] idx;
    logic [7:0]  sine_idx;
    logic [6:0]  quarter_k;
    logic [6:0]  quarter_val;
    logic [7:0]  sine_val;
    logic [7:0]  square_val;
    logic [7:0]  triangle_val;
    logic [7:0]  saw_val;
    logic [7:0]  wave_next;

    // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64.
    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] q;
        case (k)
            7'd0:  q = 7'd0;    7'd1:  q = 7'd3;    7'd2:  q = 7'd6;    7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;   7'd5:  q = 7'd16;   7'd6:  q = 7'd19;   7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;   7'd9:  q = 7'd28;   7'd10: q = 7'd31;   7'd11: q = 7'd34;
            7'd12: q = 7'd37;   7'd13: q = 7'd40;   7'd14: q = 7'd43;   7'd15: q = 7'd46;
            7'd16: q = 7'd49;   7'd17: q = 7'd51;   7'd18: q = 7'd54;   7'd19: q = 7'd57;
            7'd20: q = 7'd60;   7'd21: q = 7'd63;   7'd22: q = 7'd65;   7'd23: q = 7'd68;
            7'd24: q = 7'd71;   7'd25: q = 7'd73;   7'd26: q = 7'd76;   7'd27: q = 7'd78;
            7'd28: q = 7'd81;   7'd29: q = 7'd83;   7'd30: q = 7'd85;   7'd31: q = 7'd88;
            7'd32: q = 7'd90;   7'd33: q = 7'd92;   7'd34: q = 7'd94;   7'd35: q = 7'd96;
            7'd36: q = 7'd98;   7'd37: q = 7'd100;  7'd38: q = 7'd102;  7'd39: q = 7'd104;
            7'd40: q = 7'd106;  7'd41: q = 7'd107;  7'd42: q = 7'd109;  7'd43: q = 7'd111;
            7'd44: q = 7'd112;  7'd45: q = 7'd113;  7'd46: q = 7'd115;  7'd47: q = 7'd116;
            7'd48: q = 7'd117;  7'd49: q = 7'd118;  7'd50: q = 7'd120;  7'd51: q = 7'd121;
            7'd52: q = 7'd122;  7'd53: q = 7'd122;  7'd54: q = 7'd123;  7'd55: q = 7'd124;
            7'd56: q = 7'd125;  7'd57: q = 7'd125;  7'd58: q = 7'd126;  7'd59: q = 7'd126;
            7'd60: q = 7'd126;  7'd61: q = 7'd127;  7'd62: q = 7'd127;  7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    assign idx = acc[31:20] + PHASE_CTRL;

    // Quadrants 1 and 3 read the table backwards; the upper half is negated about 127.
    assign sine_idx    = idx[11:4];
    assign quarter_k   = sine_idx[6] ? (7'd64 - {1'b0, sine_idx[5:0]}) : {1'b0, sine_idx[5:0]};
    assign quarter_val = quarter_sine(quarter_k);
    assign sine_val    = sine_idx[7] ? (8'd127 - {1'b0, quarter_val})
                                     : (8'd127 + {1'b0, quarter_val});

    assign square_val   = idx[11] ? 8'd0 : 8'd255;
    assign triangle_val = idx[11] ? ~idx[10:3] : idx[10:3];
    assign saw_val      = idx[11:4];

    always_comb begin
        wave_next = 8'd0;
        case (wave_select)
            SEL_SINE:     wave_next = sine_val;
            SEL_SQUARE:   wave_next = square_val;
            SEL_TRIANGLE: wave_next = triangle_val;
            SEL_SAW:      wave_next = saw_val;
            default:      wave_next = 8'd0;
        endcase
    end

    // sys_rst_n is active-high despite its name.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            acc      <= 32'd0;
            wave_out <= 8'd0;
        end else begin
            acc      <= acc + FREQ_CTRL;
            wave_out <= wave_next;
        end
    end

endmodule

// File: tb/tb_dds.sv
// Scoreboard bench for dds: two instances (default and fast-sweeping parameters) checked
// against a real-arithmetic reference model of the waveform rules.
module tb_dds;

    localparam logic [31:0] F_DEF  = 32'd42949;
    localparam logic [11:0] P_DEF  = 12'd1024;
    localparam logic [31:0] F_FAST = 32'h0123_4567;
    localparam logic [11:0] P_FAST = 12'd3000;
    localparam real PI = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sel = 4'b0000;
    logic [7:0] out_def;
    logic [7:0] out_fast;

    dds dut_def (
        .sys_clk    (clk),
        .sys_rst_n  (rst),
        .wave_select(sel),
        .wave_out   (out_def)
    );

    dds #(.FREQ_CTRL(F_FAST), .PHASE_CTRL(P_FAST)) dut_fast (
        .sys_clk    (clk),
        .sys_rst_n  (rst),
        .wave_select(sel),
        .wave_out   (out_fast)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int q_def[$];
    int q_fast[$];
    logic [31:0] acc_def;
    logic [31:0] acc_fast;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int ref_sample(input logic [31:0] acc, input int phase, input logic [3:0] s);
        int p;
        int i;
        p = (int'(acc >> 20) + phase) % 4096;
        i = p / 16;
        case (s)
            4'b0001: return $rtoi(127.0 + 127.0 * $sin(2.0 * PI * real'(i) / 256.0) + 0.5);
            4'b0010: return (p < 2048) ? 255 : 0;
            4'b0100: return (p < 2048) ? ((p / 8) % 256) : (255 - ((p / 8) % 256));
            4'b1000: return i;
            default: return 0;
        endcase
    endfunction

    // Expectation for the coming rising edge, from the phase the model holds now.
    task automatic push_step(input logic [3:0] s);
        sel = s;
        q_def.push_back(ref_sample(acc_def, int'(P_DEF), s));
        q_fast.push_back(ref_sample(acc_fast, int'(P_FAST), s));
        acc_def  = acc_def + F_DEF;
        acc_fast = acc_fast + F_FAST;
    endtask

    task automatic tick(input logic [3:0] s);
        @(negedge clk);
        push_step(s);
    endtask

    task automatic release_reset(input logic [3:0] s);
        @(negedge clk);
        rst      = 1'b0;
        acc_def  = 32'd0;
        acc_fast = 32'd0;
        push_step(s);
    endtask

    task automatic hold_reset(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            sel = 4'($urandom);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        check("async_rst_def", int'(out_def), 0);
        check("async_rst_fast", int'(out_fast), 0);
        q_def.delete();
        q_fast.delete();
        hold_reset(10);
    endtask

    task automatic run_random(input int cycles);
        int done;
        int len;
        logic [3:0] s;
        done = 0;
        while (done < cycles) begin
            case ($urandom_range(0, 5))
                0: s = 4'b0001;
                1: s = 4'b0010;
                2: s = 4'b0100;
                3: s = 4'b1000;
                default: s = 4'($urandom);
            endcase
            len = $urandom_range(1, 40);
            repeat (len) tick(s);
            done += len;
        end
    endtask

    // Monitor: every edge is an output sample.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("rst_hold_def", int'(out_def), 0);
            check("rst_hold_fast", int'(out_fast), 0);
        end else begin
            if (q_def.size() > 0) check("wave_def", int'(out_def), q_def.pop_front());
            if (q_fast.size() > 0) check("wave_fast", int'(out_fast), q_fast.pop_front());
        end
    end

    initial begin
        acc_def  = 32'd0;
        acc_fast = 32'd0;
        sel      = 4'($urandom);
        hold_reset(10);

        release_reset(4'b0001);
        run_random(3000);

        mid_reset();
        release_reset(4'b0000);
        repeat (300) tick(4'b0000);

        mid_reset();
        release_reset(4'b0001);
        begin
            logic [3:0] seq [5];
            seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
            for (int k = 0; k < 5; k++) repeat (400) tick(seq[k]);
        end

        mid_reset();
        release_reset(4'b0010);
        run_random(3000);
        repeat (20) tick(4'b0000);

        @(posedge clk);
        #2;
        check("final_out_def", int'(out_def), 0);
        check("drain_def", q_def.size(), 0);
        check("drain_fast", q_fast.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
